// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: processor-status bit positions, the flag
// register layout and its reset value, and a helper that lays the flags
// out in push order.
package cpu6502_pkg;

    localparam int unsigned C_BIT = 0;
    localparam int unsigned Z_BIT = 1;
    localparam int unsigned I_BIT = 2;
    localparam int unsigned D_BIT = 3;
    localparam int unsigned B_BIT = 4;
    localparam int unsigned U_BIT = 5;
    localparam int unsigned V_BIT = 6;
    localparam int unsigned N_BIT = 7;

    // Only the six real flags are stored; B and U exist only on the bus image.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    // Interrupts masked, everything else clear.
    localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

    // Builds the byte pushed onto the stack: {N,V,1,B,D,I,Z,C}.
    function automatic logic [7:0] pack_p(input flags_t f, input logic b);
        logic [7:0] p;
        p        = '0;
        p[C_BIT] = f.c;
        p[Z_BIT] = f.z;
        p[I_BIT] = f.i;
        p[D_BIT] = f.d;
        p[B_BIT] = b;
        p[U_BIT] = 1'b1;
        p[V_BIT] = f.v;
        p[N_BIT] = f.n;
        return p;
    endfunction

endpackage

// File: rtl/status_register_if.sv
// Datapath/control bundle between the CPU core and the status register:
// data bus, opcode bit, ALU results, per-flag load strobes, SO pin, B
// value, and the flag outputs.
interface status_register_if;

    logic [7:0] i_db;
    logic       i_ir5;
    logic       i_acr;
    logic       i_avr;
    logic       i_db0_c;
    logic       i_ir5_c;
    logic       i_acr_c;
    logic       i_db1_z;
    logic       i_dbz_z;
    logic       i_db2_i;
    logic       i_ir5_i;
    logic       i_db3_d;
    logic       i_ir5_d;
    logic       i_db6_v;
    logic       i_avr_v;
    logic       i_0_v;
    logic       i_db7_n;
    logic       i_so_n;
    logic       i_b;
    logic [7:0] o_p;
    logic       o_c;
    logic       o_z;
    logic       o_i;
    logic       o_d;
    logic       o_v;
    logic       o_n;

    // Core side: drives strobes and operands, reads the flags.
    modport master (
        output i_db, i_ir5, i_acr, i_avr,
        output i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z,
        output i_db2_i, i_ir5_i, i_db3_d, i_ir5_d,
        output i_db6_v, i_avr_v, i_0_v, i_db7_n, i_so_n, i_b,
        input  o_p, o_c, o_z, o_i, o_d, o_v, o_n
    );

    // Status register side.
    modport slave (
        input  i_db, i_ir5, i_acr, i_avr,
        input  i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z,
        input  i_db2_i, i_ir5_i, i_db3_d, i_ir5_d,
        input  i_db6_v, i_avr_v, i_0_v, i_db7_n, i_so_n, i_b,
        output o_p, o_c, o_z, o_i, o_d, o_v, o_n
    );

endinterface

// File: rtl/so_edge_detect.sv
// Set-overflow pin conditioning: two-flop synchronizer, previous-value flop
// and falling-edge detect. A fall is only reported once the synchronized
// pin has been seen high after reset, so releasing reset with the pin
// already low never produces a spurious edge.
module so_edge_detect (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_so_n,
    output logic o_edge
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic valid1_q;
    logic valid2_q;
    logic armed_q;

    // Synchronize the pin, remember its last value, and arm on a real high.
    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    //       which is what turns these three flops into a pipeline.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= i_so_n;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            // valid2_q marks that sync2_q now carries a real pin sample
            // rather than the idle value forced by reset.
            valid1_q <= 1'b1;
            valid2_q <= valid1_q;
            armed_q  <= armed_q | (valid2_q & sync2_q);
        end
    end

    assign o_edge = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/status_register.sv
// 6502 processor status register. Each flag reloads from its highest
// priority active strobe and otherwise holds; a synchronized falling edge
// on SO sets V and wins over every other V source.
module status_register
    import cpu6502_pkg::*;
(
    input logic              i_clk,
    input logic              i_reset_n,
    status_register_if.slave bus
);

    flags_t flags_q;
    flags_t flags_d;
    logic   so_edge;

    so_edge_detect u_so_edge_detect (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_so_n    (bus.i_so_n),
        .o_edge    (so_edge)
    );

    // Per-flag priority select among the load strobes.
    // NOTE: flags_d starts as a copy of flags_q so every path assigns it and
    //       no latch is inferred; an idle flag simply holds.
    always_comb begin
        flags_d = flags_q;

        if (bus.i_acr_c)      flags_d.c = bus.i_acr;
        else if (bus.i_db0_c) flags_d.c = bus.i_db[0];
        else if (bus.i_ir5_c) flags_d.c = bus.i_ir5;

        if (bus.i_dbz_z)      flags_d.z = (bus.i_db == 8'h00);
        else if (bus.i_db1_z) flags_d.z = bus.i_db[1];

        if (bus.i_db2_i)      flags_d.i = bus.i_db[2];
        else if (bus.i_ir5_i) flags_d.i = bus.i_ir5;

        if (bus.i_db3_d)      flags_d.d = bus.i_db[3];
        else if (bus.i_ir5_d) flags_d.d = bus.i_ir5;

        if (so_edge)          flags_d.v = 1'b1;
        else if (bus.i_avr_v) flags_d.v = bus.i_avr;
        else if (bus.i_db6_v) flags_d.v = bus.i_db[6];
        else if (bus.i_0_v)   flags_d.v = 1'b0;

        if (bus.i_db7_n)      flags_d.n = bus.i_db[7];
    end

    // Flag flops; reset leaves interrupts masked.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) flags_q <= FLAGS_RESET;
        else            flags_q <= flags_d;
    end

    assign bus.o_p = pack_p(flags_q, bus.i_b);
    assign bus.o_c = flags_q.c;
    assign bus.o_z = flags_q.z;
    assign bus.o_i = flags_q.i;
    assign bus.o_d = flags_q.d;
    assign bus.o_v = flags_q.v;
    assign bus.o_n = flags_q.n;

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: directed scenarios followed by
// randomized strobes, SO activity and resets, all compared every cycle
// against a flag-level reference model. The SO model keeps the history of
// pin samples since reset and reports a fall when the sample taken three
// edges ago was high and the one two edges ago was low.
module tb_status_register;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    status_register_if bus ();

    status_register dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state.
    bit m_c, m_z, m_i, m_d, m_v, m_n;
    bit so_hist[$];

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clear_strobes();
        bus.i_db0_c = 0; bus.i_ir5_c = 0; bus.i_acr_c = 0;
        bus.i_db1_z = 0; bus.i_dbz_z = 0;
        bus.i_db2_i = 0; bus.i_ir5_i = 0;
        bus.i_db3_d = 0; bus.i_ir5_d = 0;
        bus.i_db6_v = 0; bus.i_avr_v = 0; bus.i_0_v = 0;
        bus.i_db7_n = 0;
    endtask

    task automatic random_strobes();
        bus.i_db    = 8'($urandom);
        bus.i_ir5   = 1'($urandom);
        bus.i_acr   = 1'($urandom);
        bus.i_avr   = 1'($urandom);
        bus.i_db0_c = ($urandom_range(3) == 0); bus.i_ir5_c = ($urandom_range(3) == 0);
        bus.i_acr_c = ($urandom_range(3) == 0); bus.i_db1_z = ($urandom_range(3) == 0);
        bus.i_dbz_z = ($urandom_range(3) == 0); bus.i_db2_i = ($urandom_range(3) == 0);
        bus.i_ir5_i = ($urandom_range(3) == 0); bus.i_db3_d = ($urandom_range(3) == 0);
        bus.i_ir5_d = ($urandom_range(3) == 0); bus.i_db6_v = ($urandom_range(3) == 0);
        bus.i_avr_v = ($urandom_range(3) == 0); bus.i_0_v   = ($urandom_range(3) == 0);
        bus.i_db7_n = ($urandom_range(3) == 0);
    endtask

    function automatic logic [7:0] exp_p();
        return {m_n, m_v, 1'b1, bus.i_b, m_d, m_i, m_z, m_c};
    endfunction

    // Apply the flag rules for the coming rising edge from the driven inputs.
    task automatic model_edge();
        int n;
        bit so_fall;
        so_hist.push_back(bus.i_so_n);
        n = so_hist.size() - 1;
        so_fall = (n >= 3) && (so_hist[n-2] == 1'b0) && (so_hist[n-3] == 1'b1);

        if (bus.i_acr_c)      m_c = bus.i_acr;
        else if (bus.i_db0_c) m_c = bus.i_db[0];
        else if (bus.i_ir5_c) m_c = bus.i_ir5;

        if (bus.i_dbz_z)      m_z = (bus.i_db == 8'h00);
        else if (bus.i_db1_z) m_z = bus.i_db[1];

        if (bus.i_db2_i)      m_i = bus.i_db[2];
        else if (bus.i_ir5_i) m_i = bus.i_ir5;

        if (bus.i_db3_d)      m_d = bus.i_db[3];
        else if (bus.i_ir5_d) m_d = bus.i_ir5;

        if (so_fall)          m_v = 1'b1;
        else if (bus.i_avr_v) m_v = bus.i_avr;
        else if (bus.i_db6_v) m_v = bus.i_db[6];
        else if (bus.i_0_v)   m_v = 1'b0;

        if (bus.i_db7_n)      m_n = bus.i_db[7];
    endtask

    // One clock: update the model, let the edge happen, compare 1 ns later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("p", bus.o_p, exp_p());
        check("flags", {2'b00, bus.o_n, bus.o_v, bus.o_d, bus.o_i, bus.o_z, bus.o_c},
              {2'b00, m_n, m_v, m_d, m_i, m_z, m_c});
    endtask

    // Reset with random strobe activity; strobes must have no effect.
    task automatic do_reset();
        rst_n = 1'b0;
        m_c = 0; m_z = 0; m_i = 1; m_d = 0; m_v = 0; m_n = 0;
        so_hist.delete();
        random_strobes();
        #1;
        check("rst_async_p", bus.o_p, {2'b00, 1'b1, bus.i_b, 4'b0100});
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_p", bus.o_p, {2'b00, 1'b1, bus.i_b, 4'b0100});
        check("rst_hold_i", {7'b0, bus.o_i}, 8'h01);
        @(negedge clk);
        clear_strobes();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        bus.i_db = 8'h00; bus.i_ir5 = 0; bus.i_acr = 0; bus.i_avr = 0;
        bus.i_so_n = 1'b1;
        bus.i_b    = 1'b1;
        clear_strobes();
        #2;

        // Reset value with B=1, then idle.
        do_reset();
        check("reset_p_34", bus.o_p, 8'h34);
        repeat (5) step();
        check("idle_p_34", bus.o_p, 8'h34);

        // Z from zero test and N from db[7].
        bus.i_db = 8'h00; bus.i_dbz_z = 1; bus.i_db7_n = 1;
        step();
        check("z_zero", {6'b0, bus.o_z, bus.o_n}, 8'h02);
        bus.i_db = 8'h80;
        step();
        check("z_nonzero", {6'b0, bus.o_z, bus.o_n}, 8'h01);
        clear_strobes();

        // C priority: acr over db0, then ir5 alone.
        bus.i_acr = 1; bus.i_acr_c = 1; bus.i_db0_c = 1; bus.i_db = 8'h00;
        step();
        check("c_acr_prio", {7'b0, bus.o_c}, 8'h01);
        clear_strobes();
        bus.i_ir5 = 0; bus.i_ir5_c = 1;
        step();
        check("c_ir5", {7'b0, bus.o_c}, 8'h00);
        clear_strobes();

        // SO latency: low sampled at edge k, V rises after edge k+2.
        bus.i_so_n = 0;
        step();
        check("so_k", {7'b0, bus.o_v}, 8'h00);
        step();
        check("so_k1", {7'b0, bus.o_v}, 8'h00);
        step();
        check("so_k2", {7'b0, bus.o_v}, 8'h01);
        // Held low; clear V at cycle 5, it must not be set again.
        step();
        bus.i_0_v = 1;
        step();
        clear_strobes();
        check("clv_held", {7'b0, bus.o_v}, 8'h00);
        repeat (5) step();
        check("so_held_once", {7'b0, bus.o_v}, 8'h00);
        bus.i_so_n = 1;
        repeat (4) step();

        // SO edge beats an AVR load of 0; CLV afterwards clears it for good.
        bus.i_so_n = 0;
        step();
        step();
        bus.i_avr = 0; bus.i_avr_v = 1;
        step();
        check("so_over_avr", {7'b0, bus.o_v}, 8'h01);
        clear_strobes();
        bus.i_0_v = 1;
        step();
        clear_strobes();
        check("clv_after_so", {7'b0, bus.o_v}, 8'h00);
        repeat (3) step();
        check("v_stays_0", {7'b0, bus.o_v}, 8'h00);

        // Reset with SO low and V set; release low must not re-set V.
        bus.i_so_n = 1;
        repeat (3) step();
        bus.i_so_n = 0;
        repeat (3) step();
        check("v_before_rst", {7'b0, bus.o_v}, 8'h01);
        do_reset();
        repeat (6) step();
        check("no_spurious_so", {7'b0, bus.o_v}, 8'h00);
        bus.i_so_n = 1;
        repeat (4) step();
        bus.i_so_n = 0;
        repeat (3) step();
        check("so_rearmed", {7'b0, bus.o_v}, 8'h01);

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 600; cyc++) begin
            random_strobes();
            bus.i_b = 1'($urandom);
            if ($urandom_range(5) == 0) bus.i_so_n = ~bus.i_so_n;
            if ($urandom_range(120) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_register.md
STATUS_REGISTER -- requirements
Module: status_register

Interface
REQ-001 Parameters: none; bit positions come from the shared package.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_db  in  8  internal data bus (flag load source; Z test source).
REQ-005 i_ir5  in  1  opcode bit 5 (set/clear value for SEC/CLC/SEI/CLI/SED/CLD).
REQ-006 i_acr, i_avr  in  1 each  ALU carry and overflow outputs, same cycle.
REQ-007 i_db0_c, i_ir5_c, i_acr_c  in  1 each  C load strobes: from db[0], ir5, acr.
REQ-008 i_db1_z, i_dbz_z  in  1 each  Z load strobes: from db[1], from (db==0).
REQ-009 i_db2_i, i_ir5_i  in  1 each  I load strobes.
REQ-010 i_db3_d, i_ir5_d  in  1 each  D load strobes.
REQ-011 i_db6_v, i_avr_v, i_0_v  in  1 each  V load strobes: db[6], avr, clear (CLV).
REQ-012 i_db7_n  in  1  N load strobe from db[7].
REQ-013 i_so_n  in  1  set-overflow pin, asynchronous, active low.
REQ-014 i_b  in  1  value presented on bit 4 of o_p (1 for BRK/PHP, 0 for IRQ/NMI push).
REQ-015 o_p  out  8  {N,V,1,B,D,I,Z,C} for push onto the data bus.
REQ-016 o_c, o_z, o_i, o_d, o_v, o_n  out  1 each  registered flag values.

Function
REQ-017 Each flag SHALL be a flop updated only on a rising edge in which at least one of its strobes is high; otherwise it holds.
REQ-018 Multiple strobes to one flag SHALL resolve by fixed priority: C: acr > db0 > ir5; Z: dbz > db1; I: db2 > ir5; D: db3 > ir5; V: so-edge > avr > db6 > clear; N: db7 only.
REQ-019 Z from i_dbz_z SHALL be 1 iff i_db == 8'h00 in that cycle.
REQ-020 o_p bit 5 SHALL be constant 1; bit 4 SHALL equal i_b combinationally; all other bits SHALL equal the flag flops (no added latency).
REQ-021 i_so_n SHALL pass a 2-flop synchronizer followed by a registered previous-value flop; a 1-to-0 transition at the synchronizer output SHALL set V on the same edge at which the edge is detected.
REQ-022 A low on i_so_n first sampled at edge k SHALL make o_v=1 after edge k+2; a held low SHALL set V once only; a pulse shorter than one period MAY be missed.
REQ-023 When the SO edge coincides with i_0_v or any V load, V SHALL be set to 1 (REQ-018).
REQ-024 Strobes SHALL be ignored while reset is asserted.

Reset
REQ-025 On i_reset_n low, asynchronously: C=Z=D=V=N=0, I=1; all synchronizer and previous-value flops = 1 (SO idle).
REQ-026 Reset asserted mid-operation SHALL discard any pending SO edge; release SHALL NOT produce a spurious SO edge, even if i_so_n is low at release.
REQ-027 Outputs after reset: o_p = {0,0,1,i_b,0,1,0,0}, o_i=1, other flag outputs 0.

Structure
REQ-028 Flag bit indices (C=0,Z=1,I=2,D=3,B=4,U=5,V=6,N=7) and reset value constant SHALL live in the shared package cpu6502_pkg.
REQ-029 The SO synchronizer and falling-edge detector SHALL be one sub-module, so_edge_detect (i_clk, i_reset_n, i_so_n, o_edge).
REQ-030 No other sub-modules; the flag logic SHALL be one clocked process plus combinational priority select.

Verification
REQ-031 Reset, i_b=1 -> o_p=8'h34; release and idle 5 cycles -> o_p unchanged.
REQ-032 i_db=8'h00, i_dbz_z=1, i_db7_n=1 for one cycle -> o_z=1, o_n=0; then i_db=8'h80, same strobes -> o_z=0, o_n=1.
REQ-033 i_acr=1, i_acr_c=1 and i_db0_c=1 with i_db=8'h00 same cycle -> o_c=1 (acr priority); i_ir5=0, i_ir5_c=1 -> o_c=0.
REQ-034 i_avr=0, i_avr_v=1 in the same cycle as a detected SO edge -> o_v=1; next cycle i_0_v=1 with i_so_n still low -> o_v=0 and stays 0.
REQ-035 i_so_n driven low at edge k -> o_v rises after edge k+2 exactly; i_so_n held low for 10 cycles and V cleared at cycle 5 -> V not re-set.
REQ-036 Assert reset while i_so_n low and V=1, release with i_so_n still low -> o_v=0 and remains 0 until i_so_n goes high then low again.
